// File: rtl/ucsbece154b_mem_arbiter_if.sv
// ucsbece154b_mem_arbiter_if: fetch, data and memory handshake bundle around the memory arbiter
interface ucsbece154b_mem_arbiter_if #(
  parameter int XLEN = 32
);
  logic            i_req;
  logic [XLEN-1:0] i_addr;
  logic [XLEN-1:0] i_rdata;
  logic            i_valid;
  logic            d_req;
  logic            d_we;
  logic [XLEN-1:0] d_addr;
  logic [XLEN-1:0] d_wdata;
  logic [XLEN-1:0] d_rdata;
  logic            d_valid;
  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] mem_rdata;
  logic            mem_ready;
  logic            stall_if;
  logic            stall_mem;
  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    input  i_rdata, i_valid, d_rdata, d_valid, mem_req, mem_we, mem_addr, mem_wdata,
           stall_if, stall_mem
  );
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    output i_rdata, i_valid, d_rdata, d_valid, mem_req, mem_we, mem_addr, mem_wdata,
           stall_if, stall_mem
  );
endinterface

// File: rtl/ucsbece154b_mem_arbiter.sv
// ucsbece154b_mem_arbiter: shares one single-ported memory between instruction fetch and data access
module ucsbece154b_mem_arbiter #(
  parameter int XLEN       = 32,
  parameter int STARVE_MAX = 4
) (
  input logic                      clk,
  input logic                      reset,
  ucsbece154b_mem_arbiter_if.slave bus
);
  localparam int CW = $clog2(STARVE_MAX + 1);
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;
  state_t        state, state_n;
  logic [CW-1:0] starve_cnt;
  logic          grant_i, grant_d, done;
  // data wins ties unless fetch has waited through STARVE_MAX data grants; any busy state ends on ready
  always_comb begin
    grant_i = (state == IDLE) && bus.i_req && (!bus.d_req || starve_cnt == CW'(STARVE_MAX));
    grant_d = (state == IDLE) && bus.d_req && !grant_i;
    done    = (state != IDLE) && bus.mem_ready;
    state_n = grant_i ? BUSY_I : grant_d ? BUSY_D : done ? IDLE : state;
  end
  assign bus.i_valid   = (state == BUSY_I) && bus.mem_ready;
  assign bus.d_valid   = (state == BUSY_D) && bus.mem_ready;
  assign bus.i_rdata   = bus.mem_rdata;
  assign bus.d_rdata   = bus.mem_rdata;
  assign bus.stall_if  = bus.i_req && !bus.i_valid;
  assign bus.stall_mem = bus.d_req && !bus.d_valid;
  // state, registered memory request captured on the grant edge, and saturating starvation count
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      starve_cnt    <= '0;
    end else begin
      state <= state_n;
      if (grant_i || grant_d) begin
        bus.mem_req   <= 1'b1;
        bus.mem_we    <= grant_d && bus.d_we;
        bus.mem_addr  <= grant_d ? bus.d_addr : bus.i_addr;
        bus.mem_wdata <= grant_d ? bus.d_wdata : {XLEN{1'b0}};
      end else if (done) begin
        bus.mem_req <= 1'b0;
      end
      if (grant_i)
        starve_cnt <= '0;
      else if (grant_d && bus.i_req && starve_cnt != CW'(STARVE_MAX))
        starve_cnt <= starve_cnt + CW'(1);
    end
  end
endmodule

// File: tb/tb_ucsbece154b_mem_arbiter.sv
// tb_ucsbece154b_mem_arbiter: scoreboard bench with requester queues and a latency-programmable memory
module tb_ucsbece154b_mem_arbiter;
  typedef struct {
    logic        is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        resp_ready = 1'b0;
  logic        spur = 1'b0;
  logic [31:0] resp_rdata = '0;
  logic        i_seen = 1'b0;
  logic        d_seen = 1'b0;
  int          lat = 0;
  int          wcnt = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  req_t        fq[$];
  req_t        dq[$];
  req_t        exp_q[$];
  always #5 clk = ~clk;
  ucsbece154b_mem_arbiter_if #(.XLEN(32)) bus();
  ucsbece154b_mem_arbiter #(.XLEN(32), .STARVE_MAX(4)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  assign bus.mem_ready = resp_ready | spur;
  assign bus.mem_rdata = spur ? 32'hBAD0BAD0 : resp_rdata;
  function automatic logic [31:0] rd_of(logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : (a ^ 32'h5A5A0000);
  endfunction
  task automatic check(string tag, logic [31:0] got, logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask
  task automatic add_f(logic [31:0] a);
    req_t r;
    r = '{1'b0, 1'b0, a, 32'h0};
    fq.push_back(r);
    exp_q.push_back(r);
  endtask
  task automatic add_d(logic we, logic [31:0] a, logic [31:0] w);
    req_t r;
    r = '{1'b1, we, a, w};
    dq.push_back(r);
    exp_q.push_back(r);
  endtask
  task automatic tick();
    req_t r;
    req_t e;
    @(negedge clk);
    if (reset || resp_ready) begin
      resp_ready = 1'b0;
      wcnt = 0;
    end else if (bus.mem_req) begin
      if (wcnt >= lat) begin
        resp_ready = 1'b1;
        resp_rdata = rd_of(bus.mem_addr);
      end else wcnt++;
    end
    if ((i_seen || !bus.i_req) && fq.size() > 0) begin
      r = fq.pop_front();
      bus.i_req = 1'b1;
      bus.i_addr = r.addr;
    end else if (i_seen) bus.i_req = 1'b0;
    if ((d_seen || !bus.d_req) && dq.size() > 0) begin
      r = dq.pop_front();
      bus.d_req = 1'b1;
      bus.d_we = r.we;
      bus.d_addr = r.addr;
      bus.d_wdata = r.wdata;
    end else if (d_seen) bus.d_req = 1'b0;
    i_seen = 1'b0;
    d_seen = 1'b0;
    #1;
    check("valid_exclusive", 32'(bus.i_valid & bus.d_valid), 0);
    if (bus.i_valid || bus.d_valid) begin
      i_seen = bus.i_valid;
      d_seen = bus.d_valid;
      if (exp_q.size() == 0) check("unexpected_valid", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("winner_is_data", 32'(bus.d_valid), 32'(e.is_d));
        check("mem_addr", bus.mem_addr, e.addr);
        check("mem_we", 32'(bus.mem_we), 32'(e.we));
        check("mem_wdata", bus.mem_wdata, e.wdata);
        if (!e.we) check("rdata", bus.d_valid ? bus.d_rdata : bus.i_rdata, rd_of(e.addr));
        if (bus.i_valid) check("stall_if_done", 32'(bus.stall_if), 0);
        else check("stall_mem_done", 32'(bus.stall_mem), 0);
      end
    end
  endtask
  task automatic drain();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || bus.i_req || bus.d_req) && k < 60) begin
      tick();
      k++;
    end
    if (k >= 60) check("drain_timeout", exp_q.size(), 0);
    tick();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.i_req = 1'b0;
    bus.i_addr = '0;
    bus.d_req = 1'b0;
    bus.d_we = 1'b0;
    bus.d_addr = '0;
    bus.d_wdata = '0;
    repeat (3) tick();
    check("rst_mem_req", 32'(bus.mem_req), 0);
    check("rst_mem_we", 32'(bus.mem_we), 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_i_valid", 32'(bus.i_valid), 0);
    check("rst_d_valid", 32'(bus.d_valid), 0);
    reset = 1'b0;
    tick();
    lat = 2;
    add_f(32'h100);
    tick();
    check("f_stall_wait", 32'(bus.stall_if), 1);
    check("f_req_not_yet", 32'(bus.mem_req), 0);
    tick();
    check("f_mem_req", 32'(bus.mem_req), 1);
    check("f_mem_addr", bus.mem_addr, 32'h100);
    check("f_mem_we", 32'(bus.mem_we), 0);
    check("f_stall_busy", 32'(bus.stall_if), 1);
    tick();
    check("f_addr_hold", bus.mem_addr, 32'h100);
    check("f_stall_hold", 32'(bus.stall_if), 1);
    drain();
    check("f_stall_after", 32'(bus.stall_if), 0);
    lat = 0;
    add_d(1'b0, 32'h200, 32'h0);
    add_f(32'h104);
    tick();
    tick();
    check("sim_data_first", bus.mem_addr, 32'h200);
    check("sim_fetch_stalled", 32'(bus.stall_if), 1);
    tick();
    check("sim_idle_gap", 32'(bus.mem_req), 0);
    drain();
    for (int k = 0; k < 4; k++) add_d(1'b0, 32'h400 + 32'(4 * k), 32'h0);
    add_f(32'h300);
    add_d(1'b0, 32'h410, 32'h0);
    add_d(1'b0, 32'h414, 32'h0);
    drain();
    add_d(1'b0, 32'h500, 32'h0);
    add_f(32'h304);
    drain();
    lat = 1;
    add_d(1'b1, 32'h40, 32'h12345678);
    tick();
    tick();
    check("st_mem_we", 32'(bus.mem_we), 1);
    check("st_mem_wdata", bus.mem_wdata, 32'h12345678);
    check("st_mem_addr", bus.mem_addr, 32'h40);
    check("st_stall", 32'(bus.stall_mem), 1);
    drain();
    lat = 5;
    dq.push_back('{1'b1, 1'b0, 32'h600, 32'h0});
    tick();
    tick();
    check("rm_busy", 32'(bus.mem_req), 1);
    reset = 1'b1;
    bus.d_req = 1'b0;
    tick();
    check("rm_mem_req", 32'(bus.mem_req), 0);
    check("rm_no_valid", 32'(bus.d_valid), 0);
    check("rm_mem_addr", bus.mem_addr, 0);
    reset = 1'b0;
    tick();
    check("rm_still_idle", 32'(bus.mem_req), 0);
    lat = 0;
    add_d(1'b0, 32'h604, 32'h0);
    drain();
    spur = 1'b1;
    tick();
    check("sp_i_valid", 32'(bus.i_valid), 0);
    check("sp_d_valid", 32'(bus.d_valid), 0);
    check("sp_mem_req", 32'(bus.mem_req), 0);
    spur = 1'b0;
    tick();
    check("sp_mem_req_after", 32'(bus.mem_req), 0);
    check("sp_mem_addr", bus.mem_addr, 32'h604);
    check("sp_mem_we", 32'(bus.mem_we), 0);
    add_d(1'b0, 32'h700, 32'h0);
    add_f(32'h308);
    drain();
    check("sb_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
